// File: rtl/colour_pkg.sv
// colour_pkg
//   Shared definitions for the colour palette: the eight standard colour
//   indices, the default channel width, the palette FSM state type and a
//   helper that builds the default table entry for a given index/width.
package colour_pkg;

  localparam int CH_W_DEFAULT = 8;
  // Widest channel the default-entry helper can describe.
  localparam int MAX_CH_W     = 32;
  localparam int ENT_W        = 3 * MAX_CH_W;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  // Default entry for index idx, packed {R,G,B} with ch_w bits per channel
  // in the low 3*ch_w bits. Index bit2/1/0 selects R/G/B fully on; indices
  // 8 and above are black. Caller truncates to its own rgb width.
  function automatic logic [ENT_W-1:0] default_entry(input int idx, input int ch_w);
    logic [ENT_W-1:0] ones;
    logic [ENT_W-1:0] ent;
    ones = (ENT_W'(1) << ch_w) - ENT_W'(1);
    ent  = '0;
    if (idx >= 0 && idx < 8) begin
      if ((idx & 4) != 0) ent = ent | (ones << (2 * ch_w));
      if ((idx & 2) != 0) ent = ent | (ones << ch_w);
      if ((idx & 1) != 0) ent = ent | ones;
    end
    return ent;
  endfunction

endpackage

// File: rtl/palette_dim.sv
// palette_dim
//   Combinational brightness dimmer: each of the three packed colour
//   channels is logically shifted right by i_dim on its own, so no bits
//   spill from one channel into the next.
//   Ports:
//     i_rgb  in  3*CH_W  packed {R,G,B}
//     i_dim  in  2       right-shift amount
//     o_rgb  out 3*CH_W  dimmed {R,G,B}
module palette_dim
  import colour_pkg::*;
#(
  parameter int CH_W = CH_W_DEFAULT
) (
  input  logic [3*CH_W-1:0] i_rgb,
  input  logic [1:0]        i_dim,
  output logic [3*CH_W-1:0] o_rgb
);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign o_rgb[gi*CH_W +: CH_W] = i_rgb[gi*CH_W +: CH_W] >> i_dim;
    end
  endgenerate

endmodule

// File: rtl/colour_palette.sv
// colour_palette
//   Writable colour palette: maps an index to a packed {R,G,B} word through
//   a two-stage registered read pipeline with per-read dimming. The table
//   lives in flops so reset reloads the standard colours directly; a
//   restore operation rewrites every entry with its default, one per cycle.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     rd_en/rd_addr/dim   read request, index and right-shift for that read
//     wr_en/wr_addr/wr_data  entry write {R,G,B}
//     restore_req         pulse: reload the default table
//     busy                restore in progress
//     rgb/rgb_valid       dimmed read result and its one-cycle valid pulse
module colour_palette
  import colour_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CH_W   = CH_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [1:0]          dim,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                restore_req,
  output logic                busy,
  output logic [3*CH_W-1:0]   rgb,
  output logic                rgb_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RGB_W = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic [RGB_W-1:0]  r_mem [DEPTH];
  logic [RGB_W-1:0]  w_def [DEPTH];

  logic              r_s1_valid;
  logic [RGB_W-1:0]  r_s1_data;
  logic [1:0]        r_s1_dim;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_rgb_valid;
  logic [RGB_W-1:0]  w_dimmed;

  logic w_idle;
  logic w_rd;
  logic w_wr;

  // Reads and writes are only honoured while idle; during a restore the
  // table port belongs to the restore counter.
  assign w_idle = (r_state == ST_IDLE);
  assign w_rd   = w_idle & rd_en;
  assign w_wr   = w_idle & wr_en;

  // Constant default table, shared by reset and the restore sequence.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_def
      assign w_def[gi] = RGB_W'(default_entry(gi, CH_W));
    end
  endgenerate

  // Restore FSM. busy is high for exactly the DEPTH cycles spent in RESTORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (restore_req) begin
            r_state <= ST_RESTORE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RESTORE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Table storage. A write in the same idle cycle as restore_req lands
  // first and is overwritten later by the restore sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_def[i];
      end
    end else if (!w_idle) begin
      r_mem[r_cnt] <= w_def[r_cnt];
    end else if (w_wr) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Stage 1: capture the entry (write-first on an address match) and dim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_dim   <= '0;
    end else begin
      r_s1_valid <= w_rd;
      if (w_rd) begin
        r_s1_data <= (w_wr && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
        r_s1_dim  <= dim;
      end
    end
  end

  palette_dim #(.CH_W(CH_W)) u_dim (
    .i_rgb (r_s1_data),
    .i_dim (r_s1_dim),
    .o_rgb (w_dimmed)
  );

  // Stage 2: rgb only changes when a result arrives, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rgb <= w_dimmed;
      end
    end
  end

  assign busy      = r_busy;
  assign rgb       = r_rgb;
  assign rgb_valid = r_rgb_valid;

endmodule

// File: doc/colour_palette.md
# colour_palette

Parametrised, writable colour palette that replaces the fixed 8-entry colour-to-RGB ROM. Maps a palette index to a packed RGB word through a 2-stage registered read pipeline with valid flag and per-read brightness dimming. Entries are runtime-writable and restorable to the standard 8-colour defaults by a sequenced restore operation. Sits between the colour/index source and the display or LED driver.

## Interface
- ADDR_W, 3, index width; DEPTH = 2**ADDR_W entries; legal values ≥ 3
- CH_W, 8, bits per colour channel; rgb word is 3*CH_W, packed {R,G,B}
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  read request, one index per cycle
- rd_addr  in  ADDR_W  palette index to read
- dim  in  2  right-shift applied to each channel of this read
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  entry to write
- wr_data  in  3*CH_W  {R,G,B} to store
- restore_req  in  1  pulse: reload default table
- busy  out  1  restore in progress
- rgb  out  3*CH_W  dimmed colour of the read
- rgb_valid  out  1  rgb holds a new result this cycle

## Operation
- Default entry i (i < 8): bit2 → R, bit1 → G, bit0 → B; a set bit gives channel all-ones, a clear bit gives zero. Index 0 black, 1 blue, 2 green, 3 cyan, 4 red, 5 magenta, 6 yellow, 7 white (CH_W=8: 0x000000, 0x0000FF, 0x00FF00, 0x00FFFF, 0xFF0000, 0xFF00FF, 0xFFFF00, 0xFFFFFF). Entries i ≥ 8 default to zero.
- Reset: table loaded with defaults; rgb=0, rgb_valid=0, busy=0, FSM in IDLE, restore counter 0.
- FSM states IDLE, RESTORE.
  - IDLE: wr_en writes wr_data to wr_addr at the clock edge. restore_req → RESTORE, counter cleared.
  - RESTORE: each cycle writes default(counter) to entry counter, then increments; after entry DEPTH-1 → IDLE. busy=1 throughout. wr_en, rd_en, restore_req ignored.
- Read-during-write: rd_en and wr_en in the same cycle at the same address return wr_data (write-first bypass).
- Dimming: each channel independently logical-shifted right by dim; no channel carries into another. dim=3 on 0xFF gives 0x1F.
- rgb holds its last value while rgb_valid=0.

## Timing
- Read latency 2: rd_en accepted at edge N (stage 1 captures entry and dim), rgb/rgb_valid updated at edge N+1, visible in cycle N+2. Full throughput, one read per cycle, no back-pressure.
- rgb_valid is a single-cycle pulse per accepted read.
- busy rises the cycle after restore_req is sampled in IDLE, stays high exactly DEPTH cycles, falls in the cycle the table is fully restored.
- Reads already in the pipeline when RESTORE starts complete normally with pre-restore data.
- restore_req and wr_en in the same IDLE cycle: the write happens, then restore overwrites it.
- restore_req and rd_en in the same IDLE cycle: the read is accepted with pre-restore data.
- Reset asserted mid-RESTORE or mid-read: table back to defaults immediately, pipeline flushed, no rgb_valid.

## Structure
- Shared package colour_pkg: colour index constants BLACK…WHITE, default CH_W, and a function returning the default entry for (index, CH_W).
- One sub-module, palette_dim: combinational per-channel shift, instantiated in stage 2.
- Storage is a flop array, so the table resets without memory initialisation files.

## Test plan
- Reset, then read indices 0–7 with dim=0 → rgb sequence 0x000000, 0x0000FF, 0x00FF00, 0x00FFFF, 0xFF0000, 0xFF00FF, 0xFFFF00, 0xFFFFFF, each valid 2 cycles after its rd_en, back-to-back.
- Write 0x123456 to index 5 and read index 5 in the same cycle → rgb=0x123456 two cycles later.
- Read index 7 with dim=1, then dim=3 → 0x7F7F7F, then 0x1F1F1F.
- ADDR_W=4: write index 12, pulse restore_req, hold rd_en/wr_en high during busy → busy high exactly 16 cycles, no rgb_valid, writes dropped. Afterwards index 12 reads 0 and index 4 reads 0xFF0000.
- Assert rst_n low mid-restore with reads in flight → rgb=0, rgb_valid=0, busy=0 immediately. After release, index 3 reads 0x00FFFF.
- CH_W=4: read index 6 → rgb=0xFF0 (12-bit).
